// File: rtl/mem2_stream_writer_pkg.sv
// Shared definitions for the byte-stream to on-chip memory writer.
package mem2_stream_writer_pkg;

   localparam int DEPTH_DEF  = 23552;
   localparam int ADDR_W_DEF = 15;
   localparam int LANES      = 4;
   localparam int LANE_W     = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem2_byte_packer.sv
// Packs accepted stream bytes little-endian into one 32-bit word and
// accumulates the matching lane enables.
module mem2_byte_packer
   import mem2_stream_writer_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 accept,
   input  logic [7:0]           data,
   output logic [8*LANES-1:0]   writedata,
   output logic [LANES-1:0]     byteenable,
   output logic                 word_full
);

   logic [LANE_W-1:0] lane;

   // The byte being accepted fills the top lane, so the word is complete.
   assign word_full = accept && (lane == LANE_W'(LANES - 1));

   // Lane counter, byte-lane register and enable accumulation.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         lane       <= '0;
         writedata  <= '0;
         byteenable <= '0;
      end else if (accept) begin
         writedata[8*lane +: 8] <= data;
         byteenable[lane]       <= 1'b1;
         lane                   <= lane + LANE_W'(1);
      end
   end

endmodule

// File: rtl/mem2_stream_writer.sv
// Writes a byte stream into consecutive 32-bit words of an on-chip memory,
// starting at a sampled base address and stopping at the end of memory.
module mem2_stream_writer
   import mem2_stream_writer_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic [ADDR_W-1:0] address,
   output logic [3:0]        byteenable,
   output logic              chipselect,
   output logic              write,
   output logic [31:0]       writedata,
   output logic              clken,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   words_written
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_t state;
   logic   last_seen;
   logic   accept;
   logic   word_full;
   logic   start_ok;
   logic   pack_clear;

   assign accept     = (state == PACK) && in_valid && in_ready;
   assign start_ok   = (state == IDLE) && start;
   // Lanes are wiped at the end of every write cycle, so the word stays
   // stable while the strobe is up and the next word starts empty.
   assign pack_clear = start_ok || (state == WRITE);
   assign clken      = ~reset;

   mem2_byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pack_clear),
      .accept     (accept),
      .data       (in_data),
      .writedata  (writedata),
      .byteenable (byteenable),
      .word_full  (word_full)
   );

   // Control FSM with registered handshake, strobe and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         in_ready      <= 1'b0;
         chipselect    <= 1'b0;
         write         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         address       <= '0;
         words_written <= '0;
         last_seen     <= 1'b0;
      end else begin
         done       <= 1'b0;
         chipselect <= 1'b0;
         write      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  address       <= base_addr;
                  words_written <= '0;
                  last_seen     <= 1'b0;
                  busy          <= 1'b1;
                  if ({1'b0, base_addr} >= DEPTH_EXT) begin
                     overflow <= 1'b1;
                     done     <= 1'b1;
                     state    <= DONE;
                  end else begin
                     overflow <= 1'b0;
                     in_ready <= 1'b1;
                     state    <= PACK;
                  end
               end
            end
            PACK: begin
               if (accept) begin
                  if (in_last) begin
                     last_seen <= 1'b1;
                  end
                  if (word_full || in_last) begin
                     in_ready   <= 1'b0;
                     chipselect <= 1'b1;
                     write      <= 1'b1;
                     state      <= WRITE;
                  end
               end
            end
            WRITE: begin
               words_written <= words_written + (ADDR_W + 1)'(1);
               if (last_seen) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (address == LAST_ADDR) begin
                  overflow <= 1'b1;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  address  <= address + ADDR_W'(1);
                  in_ready <= 1'b1;
                  state    <= PACK;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem2_stream_writer.sv
// Directed self-checking bench for mem2_stream_writer.
module tb_mem2_stream_writer;

   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          in_last;
   logic [AW-1:0] address;
   logic [3:0]    byteenable;
   logic          chipselect;
   logic          write;
   logic [31:0]   writedata;
   logic          clken;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [AW:0]   words_written;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int wr_n   = 0;
   int done_n = 0;
   int cs_err = 0;

   logic [AW-1:0] wr_addr [0:15];
   logic [31:0]   wr_data [0:15];
   logic [3:0]    wr_be   [0:15];
   int            wr_cyc  [0:15];
   int            acc_cyc [0:15];
   logic [7:0]    bytes   [0:15];

   mem2_stream_writer #(.DEPTH(23552), .ADDR_W(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .address       (address),
      .byteenable    (byteenable),
      .chipselect    (chipselect),
      .write         (write),
      .writedata     (writedata),
      .clken         (clken),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record every write strobe and done pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (write === 1'b1) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] = address;
            wr_data[wr_n] = writedata;
            wr_be[wr_n]   = byteenable;
            wr_cyc[wr_n]  = cyc;
         end
         wr_n++;
      end
      if (done === 1'b1) done_n++;
      if (chipselect !== write) cs_err++;
   end

   task automatic do_start(input logic [AW-1:0] a);
      start     = 1'b1;
      base_addr = a;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present bytes each cycle (or every other cycle) until done appears.
   task automatic drive(input int n, input int last_pos, input bit gap,
                        input int pulse_at, output int acc_n);
      int idx, budget, d0;
      bit phase;
      idx = 0; budget = 0; d0 = done_n; phase = 1'b1;
      while (done_n == d0 && budget < 200) begin
         in_valid = (idx < n) && (!gap || phase);
         in_data  = (idx < n) ? bytes[idx] : 8'h00;
         in_last  = (idx == last_pos);
         start    = (budget == pulse_at);
         if (budget == pulse_at) base_addr = 15'h0300;
         if (in_valid && in_ready) begin
            acc_cyc[idx] = cyc;
            idx++;
         end
         phase = !phase;
         budget++;
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
      acc_n = idx;
      checks++;
      if (done_n == d0) begin
         errors++;
         $display("FAIL drive_timeout: done seen=0 required=1");
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; base_addr = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, chipselect, write, busy, done, overflow, clken} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got=%b required=0000000",
                  {in_ready, chipselect, write, busy, done, overflow, clken});
      end
      checks++;
      if (address !== '0 || words_written !== '0 || byteenable !== 4'h0 || writedata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h ww=%0d be=%h wd=%h required all 0",
                  address, words_written, byteenable, writedata);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (clken !== 1'b1) begin
         errors++;
         $display("FAIL clken_after_reset: got=%b required=1", clken);
      end
   endtask

   task automatic test_two_words;
      int w0, acc;
      for (int i = 0; i < 8; i++) bytes[i] = 8'(i + 1);
      w0 = wr_n;
      do_start(15'h0010);
      drive(8, 7, 1'b0, -1, acc);
      checks++;
      if (wr_n - w0 != 2) begin
         errors++; $display("FAIL two_words_count: got=%0d required=2", wr_n - w0);
      end
      checks++;
      if (wr_addr[w0] !== 15'h0010 || wr_data[w0] !== 32'h04030201 || wr_be[w0] !== 4'hF) begin
         errors++;
         $display("FAIL two_words_w0: addr=%h data=%h be=%h required 0010 04030201 f",
                  wr_addr[w0], wr_data[w0], wr_be[w0]);
      end
      checks++;
      if (wr_addr[w0+1] !== 15'h0011 || wr_data[w0+1] !== 32'h08070605 || wr_be[w0+1] !== 4'hF) begin
         errors++;
         $display("FAIL two_words_w1: addr=%h data=%h be=%h required 0011 08070605 f",
                  wr_addr[w0+1], wr_data[w0+1], wr_be[w0+1]);
      end
      checks++;
      if (wr_cyc[w0] != acc_cyc[3] + 1) begin
         errors++;
         $display("FAIL two_words_latency: got=%0d required=%0d", wr_cyc[w0], acc_cyc[3] + 1);
      end
      checks++;
      if (wr_cyc[w0+1] - wr_cyc[w0] != 5) begin
         errors++;
         $display("FAIL two_words_throughput: got=%0d required=5", wr_cyc[w0+1] - wr_cyc[w0]);
      end
      checks++;
      if (words_written !== 16'd2 || overflow !== 1'b0 || acc != 8) begin
         errors++;
         $display("FAIL two_words_status: ww=%0d ovf=%b acc=%0d required 2 0 8",
                  words_written, overflow, acc);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL two_words_busy: got=%b required=0", busy);
      end
   endtask

   task automatic test_overflow_end;
      int w0, acc;
      bit rdy_seen;
      for (int i = 0; i < 8; i++) bytes[i] = 8'(8'hB0 + i);
      w0 = wr_n;
      do_start(15'd23551);
      drive(8, -1, 1'b0, -1, acc);
      checks++;
      if (wr_n - w0 != 1 || wr_addr[w0] !== 15'd23551 || wr_data[w0] !== 32'hB3B2B1B0) begin
         errors++;
         $display("FAIL overflow_write: n=%0d addr=%0d data=%h required 1 23551 b3b2b1b0",
                  wr_n - w0, wr_addr[w0], wr_data[w0]);
      end
      checks++;
      if (overflow !== 1'b1 || acc != 4 || words_written !== 16'd1) begin
         errors++;
         $display("FAIL overflow_status: ovf=%b acc=%0d ww=%0d required 1 4 1",
                  overflow, acc, words_written);
      end
      rdy_seen = 1'b0;
      in_valid = 1'b1; in_data = 8'hB4;
      repeat (4) begin
         @(negedge clk);
         if (in_ready) rdy_seen = 1'b1;
      end
      in_valid = 1'b0;
      checks++;
      if (rdy_seen || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_hold: ready_seen=%b ovf=%b required 0 1", rdy_seen, overflow);
      end
   endtask

   task automatic test_partial;
      int w0, acc;
      bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
      w0 = wr_n;
      do_start(15'h0100);
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL partial_ovf_clear: got=%b required=0", overflow);
      end
      drive(3, 2, 1'b0, -1, acc);
      checks++;
      if (wr_n - w0 != 1 || wr_addr[w0] !== 15'h0100 || wr_data[w0] !== 32'h00CCBBAA || wr_be[w0] !== 4'h7) begin
         errors++;
         $display("FAIL partial_write: n=%0d addr=%h data=%h be=%h required 1 0100 00ccbbaa 7",
                  wr_n - w0, wr_addr[w0], wr_data[w0], wr_be[w0]);
      end
   endtask

   task automatic test_gapped;
      int w0, acc;
      bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30; bytes[3] = 8'h40;
      w0 = wr_n;
      do_start(15'h0040);
      drive(4, 3, 1'b1, -1, acc);
      checks++;
      if (wr_n - w0 != 1 || wr_data[w0] !== 32'h40302010 || wr_be[w0] !== 4'hF || wr_addr[w0] !== 15'h0040) begin
         errors++;
         $display("FAIL gapped_write: n=%0d addr=%h data=%h be=%h required 1 0040 40302010 f",
                  wr_n - w0, wr_addr[w0], wr_data[w0], wr_be[w0]);
      end
      checks++;
      if (wr_cyc[w0] != acc_cyc[3] + 1 || acc_cyc[3] - acc_cyc[0] != 6) begin
         errors++;
         $display("FAIL gapped_timing: wr=%0d acc3=%0d acc0=%0d required wr=acc3+1 span=6",
                  wr_cyc[w0], acc_cyc[3], acc_cyc[0]);
      end
   endtask

   task automatic test_start_ignored;
      int w0, acc;
      bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
      w0 = wr_n;
      do_start(15'h0200);
      drive(4, 3, 1'b0, 1, acc);
      checks++;
      if (wr_n - w0 != 1 || wr_addr[w0] !== 15'h0200 || wr_data[w0] !== 32'h04030201) begin
         errors++;
         $display("FAIL start_ignored_write: n=%0d addr=%h data=%h required 1 0200 04030201",
                  wr_n - w0, wr_addr[w0], wr_data[w0]);
      end
      checks++;
      if (words_written !== 16'd1) begin
         errors++; $display("FAIL start_ignored_count: got=%0d required=1", words_written);
      end
   endtask

   task automatic test_base_out_of_range;
      int w0, d0;
      w0 = wr_n; d0 = done_n;
      do_start(15'd23552);
      repeat (3) @(negedge clk);
      checks++;
      if (wr_n != w0 || done_n - d0 != 1) begin
         errors++;
         $display("FAIL oob_base: writes=%0d dones=%0d required 0 1", wr_n - w0, done_n - d0);
      end
      checks++;
      if (overflow !== 1'b1 || words_written !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL oob_status: ovf=%b ww=%0d busy=%b required 1 0 0",
                  overflow, words_written, busy);
      end
   endtask

   task automatic test_reset_mid;
      int w0, acc;
      w0 = wr_n;
      do_start(15'h0020);
      in_valid = 1'b1; in_data = 8'h11;
      @(negedge clk);
      in_data = 8'h22;
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, chipselect, write, busy, done, overflow, clken} !== 7'b0 ||
          address !== '0 || words_written !== '0 || byteenable !== 4'h0 || writedata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs: flags=%b addr=%h ww=%0d be=%h wd=%h required all 0",
                  {in_ready, chipselect, write, busy, done, overflow, clken},
                  address, words_written, byteenable, writedata);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (wr_n != w0) begin
         errors++; $display("FAIL reset_mid_nowrite: got=%0d required=0", wr_n - w0);
      end
      for (int i = 0; i < 4; i++) bytes[i] = 8'(8'h41 + i);
      do_start(15'h0030);
      drive(4, 3, 1'b0, -1, acc);
      checks++;
      if (wr_n - w0 != 1 || wr_addr[w0] !== 15'h0030 || wr_data[w0] !== 32'h44434241 || wr_be[w0] !== 4'hF) begin
         errors++;
         $display("FAIL reset_mid_restart: n=%0d addr=%h data=%h be=%h required 1 0030 44434241 f",
                  wr_n - w0, wr_addr[w0], wr_data[w0], wr_be[w0]);
      end
   endtask

   initial begin
      test_reset;
      test_two_words;
      test_overflow_end;
      test_partial;
      test_gapped;
      test_start_ignored;
      test_base_out_of_range;
      test_reset_mid;
      checks++;
      if (cs_err != 0) begin
         errors++; $display("FAIL chipselect_vs_write: disagreements=%0d required=0", cs_err);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
